// File: rtl/result_read_fsm.sv
// result_read_fsm: read side of the rotating result-slot buffer.
// Tracks committed slots, streams each slot word by word from the result
// memory in commit order over a valid/ready interface, then frees the slot.
module result_read_fsm #(
   parameter int NUM_SLOTS   = 5,
   parameter int SLOT_STRIDE = 1550,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_commit,
   input  logic [LEN_W-1:0]  wr_len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready,
   output logic [2:0]        slots_used,
   output logic              slots_full,
   output logic              overflow
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_HOLD, S_RELEASE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        wr_ptr_q, wr_ptr_d;
   logic [2:0]        rd_ptr_q, rd_ptr_d;
   logic [2:0]        used_q, used_d;
   logic [LEN_W-1:0]  word_idx_q, word_idx_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              overflow_q;
   logic [LEN_W-1:0]  len_mem_q [NUM_SLOTS];

   logic              full, commit_ok, rel;
   logic [LEN_W-1:0]  len_clamped, cur_len;

   function automatic logic [2:0] ptr_inc(input logic [2:0] p);
      return (p == 3'(NUM_SLOTS - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   // Full is judged on the registered count, so a release in the same cycle
   // cannot make room for a commit.
   assign full        = (used_q == 3'(NUM_SLOTS));
   assign commit_ok   = wr_commit & ~full;
   assign rel         = (state_q == S_RELEASE);
   assign len_clamped = (wr_len > LEN_W'(SLOT_STRIDE)) ? LEN_W'(SLOT_STRIDE) : wr_len;
   assign cur_len     = len_mem_q[rd_ptr_q];

   // Slot bookkeeping: pointers and occupancy count.
   always_comb begin
      wr_ptr_d = commit_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rel ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      used_d   = 3'(used_q + {2'b00, commit_ok} - {2'b00, rel});
   end

   // Read sequencer: next state, read strobe/address and output word.
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      rd_en       = 1'b0;
      rd_addr     = '0;
      case (state_q)
         S_IDLE: begin
            if (used_q != 3'd0) begin
               if (cur_len == '0) begin
                  state_d = S_RELEASE;
               end else begin
                  word_idx_d = '0;
                  state_d    = S_READ;
               end
            end
         end
         S_READ: begin
            rd_en   = 1'b1;
            rd_addr = ADDR_W'(rd_ptr_q) * ADDR_W'(SLOT_STRIDE) + ADDR_W'(word_idx_q);
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            out_last_d  = (word_idx_q == cur_len - LEN_W'(1));
            state_d     = S_HOLD;
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (out_last_q) begin
                  state_d = S_RELEASE;
               end else begin
                  word_idx_d = word_idx_q + LEN_W'(1);
                  state_d    = S_READ;
               end
            end
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         used_q      <= '0;
         word_idx_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         overflow_q  <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) len_mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         used_q      <= used_d;
         word_idx_q  <= word_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         overflow_q  <= wr_commit & full;
         if (commit_ok) len_mem_q[wr_ptr_q] <= len_clamped;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign slots_used = used_q;
   assign slots_full = full;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_read_fsm.sv
// Bench for result_read_fsm: scenario tasks against a frame-level model of
// the expected address and output word streams.
module tb_result_read_fsm;
   localparam int NS     = 5;
   localparam int STRIDE = 1550;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_commit = 1'b0;
   logic [10:0] wr_len = '0;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic [31:0] out_data;
   logic        out_valid, out_last;
   logic        out_ready = 1'b0;
   logic [2:0]  slots_used;
   logic        slots_full, overflow;

   int n_checks = 0;
   int n_fail   = 0;

   result_read_fsm dut (
      .clk(clk), .rst(rst), .wr_commit(wr_commit), .wr_len(wr_len),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .slots_used(slots_used),
      .slots_full(slots_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Result memory: one-cycle read latency, junk when not strobed.
   always @(posedge clk) rd_data <= rd_en ? mem_word(rd_addr) : 32'hDEADBEEF;

   // Observed streams.
   logic [31:0] addr_q[$];
   logic [32:0] out_q[$];
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en) addr_q.push_back(rd_addr);
         if (out_valid && out_ready) out_q.push_back({out_last, out_data});
      end
   end

   // Frame-level model: each accepted frame occupies the next slot in turn.
   logic [31:0] exp_addr[$];
   logic [32:0] exp_out[$];
   int m_slot;

   task automatic model_frame(input int len);
      int l;
      logic [31:0] a;
      l = (len > STRIDE) ? STRIDE : len;
      for (int i = 0; i < l; i++) begin
         a = 32'(m_slot * STRIDE + i);
         exp_addr.push_back(a);
         exp_out.push_back({(i == l - 1), mem_word(a)});
      end
      m_slot = (m_slot + 1) % NS;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model;
      addr_q.delete(); out_q.delete(); exp_addr.delete(); exp_out.delete();
      m_slot = 0;
   endtask

   task automatic do_reset;
      rst = 1'b1; wr_commit = 1'b0; wr_len = '0; out_ready = 1'b0;
      tick; tick;
      rst = 1'b0;
      clear_model;
   endtask

   task automatic commit(input int len);
      wr_commit = 1'b1; wr_len = 11'(len);
      tick;
      wr_commit = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((slots_used != 0 || out_valid) && n < budget) begin tick; n++; end
      n_checks++;
      if (n >= budget) begin
         n_fail++; $display("FAIL %s_drain: timeout after %0d cycles, slots_used=%0d", name, n, slots_used);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; wr_commit = 1'b0; wr_len = '0; out_ready = 1'b0;
      tick; tick;
      n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
      n_checks++; if (rd_addr !== 32'h0) begin n_fail++; $display("FAIL rst_rd_addr: got %h want 0", rd_addr); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
      n_checks++; if (slots_used !== 3'd0) begin n_fail++; $display("FAIL rst_slots_used: got %0d want 0", slots_used); end
      n_checks++; if (slots_full !== 1'b0) begin n_fail++; $display("FAIL rst_slots_full: got %b want 0", slots_full); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      rst = 1'b0;
      tick;
      n_checks++; if (rd_en !== 1'b0 || slots_used !== 3'd0) begin
         n_fail++; $display("FAIL rst_idle: rd_en=%b slots_used=%0d want 0/0", rd_en, slots_used);
      end
   endtask

   task automatic test_single;
      int n;
      do_reset;
      out_ready = 1'b1;
      model_frame(3);
      commit(3);
      n_checks++; if (slots_used !== 3'd1 || rd_en !== 1'b0) begin
         n_fail++; $display("FAIL single_commit: slots_used=%0d rd_en=%b want 1/0", slots_used, rd_en);
      end
      tick;
      n_checks++; if (rd_en !== 1'b1 || rd_addr !== 32'h0) begin
         n_fail++; $display("FAIL single_first_rd: rd_en=%b rd_addr=%h want 1/0", rd_en, rd_addr);
      end
      // RELEASE lands 9 cycles after the first rd_en; slots_used drops one cycle later.
      n = 0;
      while (slots_used != 0 && n < 50) begin tick; n++; end
      n_checks++; if (n !== 10) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 10", n); end
      n_checks++; if (addr_q.size() != exp_addr.size() || out_q.size() != exp_out.size()) begin
         n_fail++; $display("FAIL single_count: addr %0d/%0d out %0d/%0d", addr_q.size(), exp_addr.size(), out_q.size(), exp_out.size());
      end
      for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++) begin
         n_checks++; if (addr_q[i] !== exp_addr[i]) begin n_fail++; $display("FAIL single_addr[%0d]: got %h want %h", i, addr_q[i], exp_addr[i]); end
      end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL single_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   task automatic test_backpressure;
      int n;
      logic [31:0] held;
      do_reset;
      out_ready = 1'b0;
      model_frame(2);
      commit(2);
      n = 0;
      while (!out_valid && n < 20) begin tick; n++; end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: timeout, out_valid=%b", out_valid); end
      held = out_data;
      n_checks++; if (held !== mem_word(32'h0)) begin n_fail++; $display("FAIL bp_word0: got %h want %h", held, mem_word(32'h0)); end
      for (int k = 0; k < 5; k++) begin
         tick;
         n_checks++; if (out_valid !== 1'b1 || out_data !== held || rd_en !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%h rd_en=%b want 1/%h/0", k, out_valid, out_data, rd_en, held);
         end
      end
      n_checks++; if (addr_q.size() != 1) begin n_fail++; $display("FAIL bp_reads: got %0d reads want 1", addr_q.size()); end
      drain(100, "bp");
      n_checks++; if (out_q.size() != exp_out.size()) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", out_q.size(), exp_out.size()); end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL bp_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   task automatic test_wrap;
      logic [31:0] wrap_exp[6];
      wrap_exp = '{32'h0000, 32'h060E, 32'h0C1C, 32'h122A, 32'h1838, 32'h0000};
      do_reset;
      for (int k = 0; k < 6; k++) begin
         model_frame(1);
         commit(1);
         drain(100, "wrap");
      end
      n_checks++; if (addr_q.size() != 6) begin n_fail++; $display("FAIL wrap_count: got %0d want 6", addr_q.size()); end
      for (int i = 0; i < addr_q.size() && i < 6; i++) begin
         n_checks++; if (addr_q[i] !== wrap_exp[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, addr_q[i], wrap_exp[i]); end
      end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL wrap_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   task automatic test_full;
      do_reset;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin model_frame(2); commit(2); end
      n_checks++; if (slots_used !== 3'd5 || slots_full !== 1'b1 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL full_state: used=%0d full=%b ovf=%b want 5/1/0", slots_used, slots_full, overflow);
      end
      commit(7);
      n_checks++; if (overflow !== 1'b1 || slots_used !== 3'd5) begin
         n_fail++; $display("FAIL full_overflow: ovf=%b used=%0d want 1/5", overflow, slots_used);
      end
      tick;
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_pulse: got %b want 0", overflow); end
      drain(300, "full");
      n_checks++; if (slots_full !== 1'b0) begin n_fail++; $display("FAIL full_clear: got %b want 0", slots_full); end
      n_checks++; if (addr_q.size() != exp_addr.size() || out_q.size() != exp_out.size()) begin
         n_fail++; $display("FAIL full_count: addr %0d/%0d out %0d/%0d", addr_q.size(), exp_addr.size(), out_q.size(), exp_out.size());
      end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL full_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   task automatic test_simultaneous;
      int n;
      do_reset;
      out_ready = 1'b1;
      model_frame(1); commit(1);
      model_frame(1); commit(1);
      n = 0;
      while (!(out_valid && out_last) && n < 20) begin tick; n++; end
      n_checks++; if (slots_used !== 3'd2) begin n_fail++; $display("FAIL sim_pre: used=%0d want 2", slots_used); end
      tick;  // RELEASE cycle of the first frame
      model_frame(0);
      commit(0);
      n_checks++; if (slots_used !== 3'd2) begin n_fail++; $display("FAIL sim_used: got %0d want 2", slots_used); end
      drain(100, "sim");
      n_checks++; if (addr_q.size() != exp_addr.size() || out_q.size() != exp_out.size()) begin
         n_fail++; $display("FAIL sim_count: addr %0d/%0d out %0d/%0d", addr_q.size(), exp_addr.size(), out_q.size(), exp_out.size());
      end
      for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++) begin
         n_checks++; if (addr_q[i] !== exp_addr[i]) begin n_fail++; $display("FAIL sim_addr[%0d]: got %h want %h", i, addr_q[i], exp_addr[i]); end
      end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL sim_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   task automatic test_reset_mid;
      int n;
      do_reset;
      out_ready = 1'b0;
      commit(4);
      n = 0;
      while (!out_valid && n < 20) begin tick; n++; end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin tick; n++; end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_word1: timeout, out_valid=%b", out_valid); end
      rst = 1'b1;
      tick;
      n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'h0 || rd_en !== 1'b0) begin
         n_fail++; $display("FAIL rmid_outputs: valid=%b last=%b data=%h rd_en=%b want 0", out_valid, out_last, out_data, rd_en);
      end
      n_checks++; if (slots_used !== 3'd0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL rmid_used: used=%0d ovf=%b want 0/0", slots_used, overflow);
      end
      rst = 1'b0;
      clear_model;
      out_ready = 1'b1;
      model_frame(2);
      commit(2);
      drain(100, "rmid");
      n_checks++; if (addr_q.size() == 0 || addr_q[0] !== 32'h0) begin
         n_fail++; $display("FAIL rmid_addr0: reads=%0d first=%h want 0", addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'hFFFFFFFF);
      end
      n_checks++; if (out_q.size() != exp_out.size()) begin n_fail++; $display("FAIL rmid_count: got %0d want %0d", out_q.size(), exp_out.size()); end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL rmid_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   task automatic test_clamp;
      int bad;
      do_reset;
      model_frame(2047);
      commit(2047);
      drain(6000, "clamp");
      n_checks++; if (out_q.size() != STRIDE || addr_q.size() != STRIDE) begin
         n_fail++; $display("FAIL clamp_count: out=%0d addr=%0d want %0d", out_q.size(), addr_q.size(), STRIDE);
      end
      bad = 0;
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++)
         if (out_q[i] !== exp_out[i] || addr_q[i] !== exp_addr[i]) bad++;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clamp_words: got %0d bad words want 0", bad); end
   endtask

   task automatic test_random;
      int n, issued, len;
      do_reset;
      n = 0; issued = 0;
      while ((issued < 12 || slots_used != 0 || out_valid) && n < 3000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (issued < 12 && slots_used < 4 && $urandom_range(0, 3) == 0) begin
            len = $urandom_range(0, 5);
            model_frame(len);
            wr_commit = 1'b1; wr_len = 11'(len);
            issued++;
         end else begin
            wr_commit = 1'b0;
         end
         tick; n++;
      end
      wr_commit = 1'b0;
      n_checks++; if (n >= 3000) begin n_fail++; $display("FAIL rand_timeout: %0d cycles, issued=%0d", n, issued); end
      n_checks++; if (addr_q.size() != exp_addr.size() || out_q.size() != exp_out.size()) begin
         n_fail++; $display("FAIL rand_count: addr %0d/%0d out %0d/%0d", addr_q.size(), exp_addr.size(), out_q.size(), exp_out.size());
      end
      for (int i = 0; i < addr_q.size() && i < exp_addr.size(); i++) begin
         n_checks++; if (addr_q[i] !== exp_addr[i]) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h want %h", i, addr_q[i], exp_addr[i]); end
      end
      for (int i = 0; i < out_q.size() && i < exp_out.size(); i++) begin
         n_checks++; if (out_q[i] !== exp_out[i]) begin n_fail++; $display("FAIL rand_out[%0d]: got %h want %h", i, out_q[i], exp_out[i]); end
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_backpressure;
      test_wrap;
      test_full;
      test_simultaneous;
      test_reset_mid;
      test_clamp;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule

// File: doc/result_read_fsm.md
Name: result_read_fsm

Overview:
- Read-side counterpart of the output-FIFO write-address rotation.
- Tracks which of the 5 fixed result slots hold committed results.
- Reads each committed slot word by word from the result memory, in commit order.
- Streams the words to the downstream interface with a valid/ready handshake, then frees the slot for the write side.

Parameters:
- NUM_SLOTS, 5, number of rotating result slots.
- SLOT_STRIDE, 1550 (0x060E), word offset between consecutive slot bases.
- ADDR_W, 32, result-memory address width.
- DATA_W, 32, result-memory and output data width.
- LEN_W, 11, width of slot length field in words.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_commit  in  1  one-cycle pulse: write side finished a slot; same event that advances the write address.
- wr_len  in  LEN_W  words in the slot being committed; sampled when wr_commit=1.
- rd_en  out  1  result-memory read strobe.
- rd_addr  out  ADDR_W  result-memory read address.
- rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en.
- out_data  out  DATA_W  output word.
- out_valid  out  1  out_data is valid.
- out_last  out  1  final word of the current slot; qualified by out_valid.
- out_ready  in  1  downstream accepts the word when out_valid&out_ready.
- slots_used  out  3  number of committed, unreleased slots (0..5).
- slots_full  out  1  slots_used==NUM_SLOTS; the write side must not commit while high.
- overflow  out  1  one-cycle pulse when a commit arrives while full.

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, all outputs 0, wr_ptr=rd_ptr=0, slots_used=0. Reset aborts any in-progress slot; that slot's remaining data is discarded.
- Commit bookkeeping:
  - On wr_commit with not full: len_mem[wr_ptr] <= min(wr_len, SLOT_STRIDE); wr_ptr advances 0→1→2→3→4→0; slots_used+1.
  - On wr_commit while full: commit ignored, pointers and count unchanged, overflow=1 next cycle for one cycle.
- Slot bases are rd_ptr*SLOT_STRIDE: 0x0000, 0x060E, 0x0C1C, 0x122A, 0x1838. rd_addr = base + word_idx, zero-extended to ADDR_W.
- Slot lifecycle:
  - A slot is committed when the write side pulses wr_commit; it is released only after this block has read and handed off its final word.
  - The slot at rd_ptr is "current".
- State machine:
  - IDLE: if slots_used>0 and len_mem[rd_ptr]==0 → RELEASE; if slots_used>0 and length ≥1 → READ, word_idx=0; else stay.
  - READ: rd_en=1 for exactly one cycle, rd_addr as above → CAPTURE.
  - CAPTURE: out_data<=rd_data, out_valid<=1, out_last<=(word_idx==len-1) → HOLD.
  - HOLD: out_data/out_last stable while out_valid&!out_ready. On out_ready: out_valid<=0. If out_last → RELEASE; else word_idx+1 → READ.
  - RELEASE: rd_ptr advances with the same 4→0 wrap; slots_used-1 → IDLE.
- Throughput: minimum 3 cycles per word (READ, CAPTURE, HOLD with out_ready=1).
- First rd_en occurs 1 cycle after IDLE sees slots_used>0. slots_used reflects a commit the cycle after wr_commit.
- Commit and release in the same cycle: slots_used unchanged; both pointers advance.
- A commit in the same cycle as a full-to-release transition is still rejected: full is evaluated before release.
- rd_en=0 in all states except READ.
- out_valid never deasserts without a handshake, except on reset.
- len_mem lengths are clamped to SLOT_STRIDE; word_idx never exceeds len-1.

Test Plan:
- Single slot: commit wr_len=3, out_ready=1 → rd_addr 0x0,0x1,0x2; rd_data A,B,C delivered in order, out_last only with C; slots_used 1→0; 9 cycles from first rd_en to release.
- Backpressure: commit wr_len=2, hold out_ready=0 for 5 cycles on word 0 → out_data/out_valid stable, no second rd_en until the handshake.
- Wrap: six sequential frames, wr_len=1 each, drained before each next commit → rd_addr sequence 0x0000,0x060E,0x0C1C,0x122A,0x1838,0x0000.
- Full/overflow: five commits with out_ready=0, then a sixth → slots_full=1, overflow pulses one cycle, slots_used stays 5, sixth frame never read.
- Simultaneous: wr_commit on the RELEASE cycle with slots_used=2 → slots_used stays 2; a zero-length commit produces no rd_en and no output, only a release.
- Reset mid-frame: assert rst during HOLD of word 1 of 4 → next cycle all outputs 0, slots_used=0; a new commit reads from 0x0000.
